// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: note codes, sequencer states,
// entry field widths and the note-to-LED one-hot decode.
package song_sequencer_pkg;

    localparam int NOTE_W    = 4;
    localparam int DUR_W_DEF = 4;
    localparam int LED_W     = 8;

    localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D    = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_E    = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_F    = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_G    = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_A    = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_B    = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP, ST_DONE} state_t;

    // Codes above C5 are not playable and collapse to silence.
    function automatic logic [NOTE_W-1:0] note_clean(input logic [NOTE_W-1:0] n);
        note_clean = (n > NOTE_C5) ? NOTE_NONE : n;
    endfunction

    // C4 lights the MSB, C5 the LSB; silence lights nothing.
    function automatic logic [LED_W-1:0] note_to_led(input logic [NOTE_W-1:0] n);
        note_to_led = '0;
        if (n >= NOTE_C4 && n <= NOTE_C5)
            note_to_led = 8'h80 >> (n - NOTE_C4);
    endfunction

endpackage

// File: rtl/song_sequencer_rom.sv
// Song ROM: Ode to Joy as {note, duration} entries, zero duration ends the song.
module song_sequencer_rom
    import song_sequencer_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DUR_W  = DUR_W_DEF
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NOTE_W-1:0] note_o,
    output logic [DUR_W-1:0]  dur_o
);

    always_comb begin
        note_o = NOTE_NONE;
        dur_o  = '0;
        case (int'(addr_i))
            0, 1, 6, 11: begin note_o = NOTE_E;  dur_o = DUR_W'(2); end
            2, 5:        begin note_o = NOTE_F;  dur_o = DUR_W'(2); end
            3, 4:        begin note_o = NOTE_G;  dur_o = DUR_W'(2); end
            7, 10:       begin note_o = NOTE_D;  dur_o = DUR_W'(2); end
            8, 9:        begin note_o = NOTE_C4; dur_o = DUR_W'(2); end
            12:          begin note_o = NOTE_E;  dur_o = DUR_W'(3); end
            13:          begin note_o = NOTE_D;  dur_o = DUR_W'(1); end
            14:          begin note_o = NOTE_D;  dur_o = DUR_W'(4); end
            default:     begin note_o = NOTE_NONE; dur_o = '0; end
        endcase
    end

endmodule

// File: rtl/song_sequencer.sv
// Autoplay song sequencer paced by beat_tick. Define SONG_GAP_EN to insert a
// one-tick silent gap after every entry.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DUR_W  = DUR_W_DEF,
    parameter int LOOP   = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              beat_tick,
    input  logic              start,
    input  logic              stop,
    output logic [NOTE_W-1:0] note,
    output logic [LED_W-1:0]  Led,
    output logic              playing,
    output logic              done,
    output logic [ADDR_W-1:0] index
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [DUR_W-1:0]    cnt_q, cnt_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [LED_W-1:0]    led_q;
    logic                playing_q, done_q;

    logic [NOTE_W-1:0]   first_note, next_note;
    logic [DUR_W-1:0]    first_dur, next_dur;

    state_t              lf_state, adv_state;
    logic [NOTE_W-1:0]   lf_note, adv_note;
    logic [DUR_W-1:0]    lf_cnt, adv_cnt;
    logic [ADDR_W-1:0]   adv_index;

    song_sequencer_rom #(.ADDR_W(ADDR_W), .DUR_W(DUR_W)) u_rom_first (
        .addr_i (ADDR_W'(0)),
        .note_o (first_note),
        .dur_o  (first_dur)
    );

    song_sequencer_rom #(.ADDR_W(ADDR_W), .DUR_W(DUR_W)) u_rom_next (
        .addr_i (index_q + ADDR_W'(1)),
        .note_o (next_note),
        .dur_o  (next_dur)
    );

    // Result of (re)starting at entry 0; an empty song never enters PLAY.
    always_comb begin
        lf_state = ST_PLAY;
        lf_note  = note_clean(first_note);
        lf_cnt   = first_dur;
        if (first_dur == '0) begin
            lf_state = (LOOP != 0) ? ST_IDLE : ST_DONE;
            lf_note  = NOTE_NONE;
        end
    end

    // Result of finishing the current entry; the top address always ends the song.
    always_comb begin
        adv_state = ST_PLAY;
        adv_index = index_q + ADDR_W'(1);
        adv_note  = note_clean(next_note);
        adv_cnt   = next_dur;
        if ((&index_q) || next_dur == '0) begin
            if (LOOP != 0) begin
                adv_state = lf_state;
                adv_index = '0;
                adv_note  = lf_note;
                adv_cnt   = lf_cnt;
            end else begin
                adv_state = ST_DONE;
                adv_index = index_q;
                adv_note  = NOTE_NONE;
                adv_cnt   = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        note_d  = note_q;
        if (stop) begin
            state_d = ST_IDLE;
            index_d = '0;
            cnt_d   = '0;
            note_d  = NOTE_NONE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = lf_state;
                        index_d = '0;
                        cnt_d   = lf_cnt;
                        note_d  = lf_note;
                    end
                end
                ST_PLAY: begin
                    if (beat_tick) begin
                        if (cnt_q > DUR_W'(1)) begin
                            cnt_d = cnt_q - DUR_W'(1);
                        end else begin
`ifdef SONG_GAP_EN
                            state_d = ST_GAP;
                            cnt_d   = '0;
                            note_d  = NOTE_NONE;
`else
                            state_d = adv_state;
                            index_d = adv_index;
                            cnt_d   = adv_cnt;
                            note_d  = adv_note;
`endif
                        end
                    end
                end
`ifdef SONG_GAP_EN
                ST_GAP: begin
                    if (beat_tick) begin
                        state_d = adv_state;
                        index_d = adv_index;
                        cnt_d   = adv_cnt;
                        note_d  = adv_note;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    index_d = '0;
                    cnt_d   = '0;
                    note_d  = NOTE_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            cnt_q     <= '0;
            note_q    <= NOTE_NONE;
            led_q     <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            cnt_q     <= cnt_d;
            note_q    <= note_d;
            led_q     <= note_to_led(note_d);
            playing_q <= (state_d == ST_PLAY) || (state_d == ST_GAP);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign note    = note_q;
    assign Led     = led_q;
    assign playing = playing_q;
    assign done    = done_q;
    assign index   = index_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: one LOOP=0 and one LOOP=1 instance share stimulus and
// are checked every cycle against a tick-count timeline model of the song.
module tb_song_sequencer;

`ifdef SONG_GAP_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif
    localparam int NENT = 15;

    logic CLK = 1'b0;
    logic RESET, beat_tick, start, stop;
    logic [3:0] note_w    [2];
    logic [7:0] led_w     [2];
    logic       playing_w [2];
    logic       done_w    [2];
    logic [4:0] index_w   [2];

    int vectors     = 0;
    int miscompares = 0;

    int song_note [NENT] = '{3, 3, 4, 5, 5, 4, 3, 2, 1, 1, 2, 3, 3, 2, 2};
    int song_dur  [NENT] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 1, 4};

    bit m_active [2];
    int m_ticks  [2];

    always #5 CLK = ~CLK;

    song_sequencer #(.ADDR_W(5), .DUR_W(4), .LOOP(0)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .beat_tick(beat_tick), .start(start), .stop(stop),
        .note(note_w[0]), .Led(led_w[0]), .playing(playing_w[0]), .done(done_w[0]),
        .index(index_w[0])
    );

    song_sequencer #(.ADDR_W(5), .DUR_W(4), .LOOP(1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .beat_tick(beat_tick), .start(start), .stop(stop),
        .note(note_w[1]), .Led(led_w[1]), .playing(playing_w[1]), .done(done_w[1]),
        .index(index_w[1])
    );

    function automatic int song_total();
        int s = 0;
        for (int i = 0; i < NENT; i++) s += song_dur[i] + G;
        return s;
    endfunction

    function automatic bit finished(input int k);
        return (k == 0) && m_active[0] && (m_ticks[0] >= song_total());
    endfunction

    // Position in the song is just the number of ticks since start, laid on the
    // timeline of entry spans (dur ticks of note, then G ticks of silence).
    function automatic void expect_out(input int k, output int en, output int ei,
                                       output int ep, output int ed);
        int t;
        en = 0; ei = 0; ep = 0; ed = 0;
        if (!m_active[k]) return;
        if (finished(k)) begin
            ei = NENT - 1; ed = 1;
            return;
        end
        ep = 1;
        t = m_ticks[k] % song_total();
        for (int i = 0; i < NENT; i++) begin
            if (t < song_dur[i] + G) begin
                ei = i;
                en = (t < song_dur[i]) ? song_note[i] : 0;
                return;
            end
            t -= song_dur[i] + G;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK or posedge RESET) begin
        for (int k = 0; k < 2; k++) begin
            if (RESET) begin
                m_active[k] <= 1'b0;
                m_ticks[k]  <= 0;
            end else if (stop) begin
                m_active[k] <= 1'b0;
                m_ticks[k]  <= 0;
            end else if (start && (!m_active[k] || finished(k))) begin
                m_active[k] <= 1'b1;
                m_ticks[k]  <= 0;
            end else if (m_active[k] && !finished(k) && beat_tick) begin
                m_ticks[k]  <= m_ticks[k] + 1;
            end
        end
    end

    always @(negedge CLK) begin
        int en, ei, ep, ed;
        for (int k = 0; k < 2; k++) begin
            expect_out(k, en, ei, ep, ed);
            check($sformatf("dut%0d_note", k), int'(note_w[k]), en);
            check($sformatf("dut%0d_led", k), int'(led_w[k]),
                  (en >= 1 && en <= 8) ? (1 << (8 - en)) : 0);
            check($sformatf("dut%0d_index", k), int'(index_w[k]), ei);
            check($sformatf("dut%0d_playing", k), int'(playing_w[k]), ep);
            check($sformatf("dut%0d_done", k), int'(done_w[k]), ed);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            beat_tick = 1'b1;
            cyc(1);
            beat_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; beat_tick = 1'b0; start = 1'b0; stop = 1'b0;
        cyc(2);
        RESET = 1'b0;
        cyc(1);
        check("reset_note", int'(note_w[0]), 0);
        check("reset_index", int'(index_w[0]), 0);
        check("reset_playing", int'(playing_w[0]), 0);

        pulse_start();
        check("start_note", int'(note_w[0]), 3);
        check("start_led", int'(led_w[0]), 8'b0010_0000);
        check("start_playing", int'(playing_w[0]), 1);
        cyc(5);
        check("hold_note", int'(note_w[0]), 3);

`ifdef SONG_GAP_EN
        tick(2);
        check("gap_note", int'(note_w[0]), 0);
        check("gap_playing", int'(playing_w[0]), 1);
        tick(1);
        check("after_gap_note", int'(note_w[0]), 3);
        check("after_gap_index", int'(index_w[0]), 1);
        tick(song_total() - 3);
`else
        tick(2);
        check("t2_note", int'(note_w[0]), 3);
        check("t2_index", int'(index_w[0]), 1);
        tick(2);
        check("t4_note", int'(note_w[0]), 4);
        check("t4_led", int'(led_w[0]), 8'b0001_0000);
        check("t4_index", int'(index_w[0]), 2);
        tick(song_total() - 4);
`endif
        check("end_note", int'(note_w[0]), 0);
        check("end_done", int'(done_w[0]), 1);
        check("end_index", int'(index_w[0]), 14);
        check("loop_wrap_note", int'(note_w[1]), 3);
        check("loop_wrap_index", int'(index_w[1]), 0);
        tick(3);
        pulse_start();
        check("restart_note", int'(note_w[0]), 3);
        check("restart_index", int'(index_w[0]), 0);

        tick(3);
        start = 1'b1; beat_tick = 1'b1;
        cyc(1);
        start = 1'b0; beat_tick = 1'b0;
        cyc(1);
        stop = 1'b1; start = 1'b1;
        cyc(1);
        stop = 1'b0; start = 1'b0;
        check("stop_note", int'(note_w[0]), 0);
        check("stop_index", int'(index_w[0]), 0);
        check("stop_playing", int'(playing_w[0]), 0);
        cyc(2);

        start = 1'b1; beat_tick = 1'b1;
        cyc(1);
        start = 1'b0; beat_tick = 1'b0;
        check("start_tick_note", int'(note_w[0]), 3);
        tick(1);
        check("start_tick_index", int'(index_w[0]), 0);
        check("start_tick_note2", int'(note_w[0]), 3);
        tick(4);

        #1 RESET = 1'b1;
        #1;
        check("async_rst_note", int'(note_w[0]), 0);
        check("async_rst_playing", int'(playing_w[0]), 0);
        cyc(2);
        RESET = 1'b0;
        cyc(1);

        pulse_start();
        tick(2 * song_total() + 5);
        check("loop_long_done", int'(done_w[1]), 0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Upstream autoplay source for the piano top level: walks a song ROM and emits one 4-bit note code at a time, paced by the beat tick from the clock manager.
- Drives the top level's autoplay note selection and its autoplay LED bus.
- Entries hold {note, duration in beat ticks}; a zero-duration entry marks end of song.

Parameters:
- ADDR_W, 5, song ROM address width (max 32 entries).
- DUR_W, 4, duration field width in beat ticks.
- LOOP, 0, when 1, restart from entry 0 at end of song instead of entering DONE.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  reset, asynchronous, active-high.
- beat_tick  in  1  one-CLK pulse per beat unit (quarter beat), synchronous to CLK.
- start  in  1  one-CLK pulse; begins playback from entry 0.
- stop  in  1  one-CLK pulse; aborts playback.
- note  out  4  current note code (0 = none).
- Led  out  8  one-hot LED for current note (all-zero when none).
- playing  out  1  high in PLAY (and GAP).
- done  out  1  high in DONE.
- index  out  ADDR_W  current ROM entry.

Behaviour:
- Reset values:
  - state IDLE
  - note 0, Led 0, playing 0, done 0, index 0
  - duration counter 0
- Note codes: NONE=0, C4=1, D=2, E=3, F=4, G=5, A=6, B=7, C5=8. Codes 9-15 are treated as NONE.
- LED mapping: C4 drives Led[7], D Led[6], and so on down to C5 on Led[0]. Led is registered in the same cycle as note.
- All outputs are registered.
- IDLE:
  - note=0.
  - start: next edge enters PLAY with index=0, note=rom[0].note, cnt=rom[0].dur.
  - If rom[0].dur==0, go directly to DONE (or stay IDLE when LOOP=1).
- PLAY:
  - Each beat_tick with cnt>1: cnt decrements.
  - beat_tick with cnt==1: advance to idx+1 and load its note and dur on that edge.
  - If the next entry has dur==0:
    - LOOP=0: go to DONE, note=0, index holds the last played entry.
    - LOOP=1: load entry 0.
  - No beat_tick: hold.
- DONE: note=0, done=1. start re-enters PLAY from entry 0, exactly as from IDLE.
- Stop: in any state, next edge goes to IDLE with note=0, index=0, done=0.
- Simultaneous start and stop: stop wins.
- start while in PLAY or GAP is ignored.
- start and beat_tick in the same cycle from IDLE: the entry is loaded and the tick is not counted.
- Index wrap: if index == 2^ADDR_W-1 and that entry completes, the next entry is treated as end-of-song.
- Latency: note changes on the CLK edge that samples the terminating beat_tick (1 cycle).
- RESET mid-song: immediate asynchronous return to reset values.

Optional Feature:
- Macro: SONG_GAP_EN.
- Defined:
  - After an entry's duration expires, the block enters GAP for exactly one beat_tick with note=0, Led=0, playing=1.
  - The next beat_tick loads the next entry.
  - Repeated notes become audibly separated; total per-entry time is dur+1 ticks.
  - End-of-song is checked when leaving GAP.
  - stop in GAP goes to IDLE.
- Undefined: no GAP state exists and entries play back-to-back.

Decomposition:
- Shared package/include holds:
  - note code constants (NONE, C4..C5)
  - the note-to-LED one-hot function
  - state encodings (IDLE, PLAY, GAP, DONE)
  - entry field widths
- The existing top-level parameters include re-uses the same note constants.
- Sub-module song_rom: combinational read of {note[3:0], dur[DUR_W-1:0]} by index.
- Song contents: Ode to Joy, starting E/2, E/2, F/2, G/2, G/2, F/2, E/2, D/2, C4/2, C4/2, D/2, E/2, E/3, D/1, D/4, then an end marker.

Test Plan:
- Reset then start pulse, no ticks -> next cycle note=3 (E), Led=8'b0010_0000, playing=1, index=0. Values hold indefinitely.
- Apply 2 beat_ticks -> note stays 3 and index becomes 1. After 2 more ticks, note=4 (F), Led=8'b0001_0000, index=2.
- Run 15 entries to completion (LOOP=0) -> after the final D/4, note=0, done=1, index=14. Then a start pulse gives note=3, index=0.
- stop and start asserted in the same cycle during PLAY -> IDLE, note=0, index=0, playing=0. RESET asserted between edges clears outputs without waiting for CLK.
- LOOP=1 with a 2-entry test ROM (C4/1, G/1, end) -> note sequence 1, 5, 1, 5 per tick; done never asserts.
- SONG_GAP_EN defined -> E/2 is followed by exactly one tick of note=0, then E. Entry 1 loads on the 3rd tick after start.
